// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU/MDU execute unit: decoded ALU codes,
// ALUOp classes, M-extension ops and the sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_ctrl_e;

  typedef enum logic [1:0] {OP_MEM, OP_BRANCH, OP_RTYPE, OP_ITYPE} alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [2:0] {ST_IDLE, ST_ALU, ST_MUL, ST_DIV, ST_SIGN, ST_FIX} state_e;

  localparam logic [6:0] FUNC7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

  // DIV/DIVU/REM/REMU all have func3[2] set.
  function automatic logic is_div_op(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle between the EX-stage control FSM (master) and the
// ALU/MDU sequencer (slave).
interface alu_mdu_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      alu_op;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            busy;
  logic            done;

  modport master (output start, alu_op, func3, func7, op_a, op_b,
                  input  result, branch_taken, busy, done);
  modport slave  (input  start, alu_op, func3, func7, op_a, op_b,
                  output result, branch_taken, busy, done);
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/func3/func7 decoder: base ALU code plus M-extension
// detection and M-op selection.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output alu_ctrl_e  alu_ctrl,
  output logic       is_mext,
  output md_op_e     md_op
);

  alu_op_e op;
  assign op      = alu_op_e'(alu_op);
  assign is_mext = (op == OP_RTYPE) && (func7 == FUNC7_MEXT);
  assign md_op   = md_op_e'(func3);

  always_comb begin
    // NOTE: default assignment first so no path leaves alu_ctrl unassigned (no latch).
    alu_ctrl = ALU_ADD;
    case (op)
      OP_BRANCH: begin
        case (func3)
          3'b001:  alu_ctrl = ALU_BNE;
          3'b100:  alu_ctrl = ALU_BLT;
          3'b101:  alu_ctrl = ALU_BGE;
          3'b110:  alu_ctrl = ALU_BLTU;
          3'b111:  alu_ctrl = ALU_BGEU;
          default: alu_ctrl = ALU_BEQ;
        endcase
      end
      OP_RTYPE, OP_ITYPE: begin
        case (func3)
          // Immediate forms have no SUB; func7 bits there are immediate bits.
          3'b000:  alu_ctrl = (op == OP_RTYPE && func7 == FUNC7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = (func7 == FUNC7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage execute unit: single-cycle RV32I ALU/branch ops, bit-serial RV32M
// multiply (shift-add) and divide (restoring) sharing one XLEN+1 adder.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  alu_mdu_seq_if.slave bus
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CNT_W   = SHAMT_W + 1;

  alu_ctrl_e dec_ctrl;
  logic      dec_mext;
  md_op_e    dec_md;

  alu_ctrl_decode u_decode (
    .alu_op  (bus.alu_op),
    .func3   (bus.func3),
    .func7   (bus.func7),
    .alu_ctrl(dec_ctrl),
    .is_mext (dec_mext),
    .md_op   (dec_md)
  );

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            branch_q, branch_d, done_q, done_d, busy_q, busy_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  md_op_e          md_q, md_d;
  logic            neg_q, neg_d, neg_r_q, neg_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Base ALU on the live operands: the result is registered on the accept edge.
  logic [XLEN-1:0]    a, b, sub_ab, alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               slt, sltu, alu_taken;

  assign a      = bus.op_a;
  assign b      = bus.op_b;
  assign sub_ab = a - b;
  assign slt    = $signed(a) < $signed(b);
  assign sltu   = a < b;
  assign shamt  = b[SHAMT_W-1:0];

  always_comb begin
    alu_res   = sub_ab;
    alu_taken = 1'b0;
    case (dec_ctrl)
      ALU_ADD:  alu_res = a + b;
      ALU_SLL:  alu_res = a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, sltu};
      ALU_XOR:  alu_res = a ^ b;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = $signed(a) >>> shamt;
      ALU_OR:   alu_res = a | b;
      ALU_AND:  alu_res = a & b;
      ALU_BEQ:  alu_taken = (a == b);
      ALU_BNE:  alu_taken = (a != b);
      ALU_BLT:  alu_taken = slt;
      ALU_BGE:  alu_taken = !slt;
      ALU_BLTU: alu_taken = sltu;
      ALU_BGEU: alu_taken = !sltu;
      default:  alu_res = sub_ab;
    endcase
  end

  // Operand signedness and the RISC-V divide corner cases, also from live inputs.
  logic            a_signed, b_signed, a_sgn, b_sgn, is_div, is_rem, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, fix_res;

  assign a_signed = dec_md inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  assign b_signed = dec_md inside {MD_MULH, MD_DIV, MD_REM};
  assign a_sgn    = a_signed & a[XLEN-1];
  assign b_sgn    = b_signed & b[XLEN-1];
  assign mag_a    = a_sgn ? -a : a;
  assign mag_b    = b_sgn ? -b : b;
  assign is_div   = is_div_op(dec_md);
  assign is_rem   = dec_md inside {MD_REM, MD_REMU};
  assign div_zero = (b == '0);
  assign div_ovf  = (dec_md inside {MD_DIV, MD_REM}) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign fix_res  = is_rem ? (div_zero ? a : '0) : (div_zero ? '1 : a);

  // Shared adder: MUL accumulates hi+multiplicand, DIV trial-subtracts the divisor.
  // Bit XLEN+1 of a subtraction is the no-borrow flag (minuend >= divisor).
  logic [XLEN:0]   add_x, add_y, mul_new;
  logic            add_sub;
  logic [XLEN+1:0] add_sum;

  assign add_sub = (state_q == ST_DIV);
  assign add_x   = add_sub ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
  assign add_y   = {1'b0, opb_q};
  assign add_sum = {1'b0, add_x} + {1'b0, add_sub ? ~add_y : add_y} + (XLEN+2)'(add_sub);
  assign mul_new = lo_q[0] ? add_sum[XLEN:0] : {1'b0, hi_q};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, sign_res;

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_r_q ? -hi_q : hi_q;

  always_comb begin
    case (md_q)
      MD_MUL:                       sign_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: sign_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              sign_res = quo_fix;
      default:                      sign_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    md_d     = md_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (!dec_mext) begin
            result_d = alu_res;
            branch_d = alu_taken;
            done_d   = 1'b1;
            state_d  = ST_ALU;
          end else if (is_div && (div_zero || div_ovf)) begin
            result_d = fix_res;
            branch_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_FIX;
          end else begin
            hi_d    = '0;
            lo_d    = mag_a;
            opb_d   = mag_b;
            md_d    = dec_md;
            neg_d   = a_sgn ^ b_sgn;
            neg_r_d = a_sgn;
            cnt_d   = CNT_W'(XLEN);
            busy_d  = 1'b1;
            state_d = is_div ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL: begin
        hi_d  = mul_new[XLEN:1];
        lo_d  = {mul_new[0], lo_q[XLEN-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_SIGN;
      end
      ST_DIV: begin
        if (add_sum[XLEN+1]) begin
          hi_d = add_sum[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        result_d = sign_res;
        branch_d = 1'b0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      branch_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // NOTE: datapath registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    opb_q   <= opb_d;
    md_q    <= md_d;
    neg_q   <= neg_d;
    neg_r_q <= neg_r_d;
    cnt_q   <= cnt_d;
  end

  assign bus.result       = result_q;
  assign bus.branch_taken = branch_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq: expected result/branch/latency
// pushed to a scoreboard on launch, popped and compared when done arrives.
module tb_alu_mdu_seq;
  import alu_pkg::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mdu_seq_if #(.XLEN(XLEN)) bus ();

  alu_mdu_seq #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [XLEN-1:0] result;
    logic            taken;
    int              lat;
    logic            busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.alu_op = op;
    bus.func3  = f3;
    bus.func7  = f7;
    bus.op_a   = a;
    bus.op_b   = b;
  endtask

  // Launch one op, scramble the inputs after the accept edge, then wait for done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_res, input logic exp_tk, input int exp_lat,
                        input logic exp_busy);
    exp_t e;
    int   lat;
    logic busy1;
    sb_q.push_back('{exp_res, exp_tk, exp_lat, exp_busy});
    @(negedge clk);
    drive(op, f3, f7, a, b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drive(op, ~f3, ~f7, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    lat   = 1;
    busy1 = bus.busy;
    while (bus.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    check({tag, ".lat"}, lat, e.lat);
    check({tag, ".result"}, bus.result, e.result);
    check({tag, ".taken"}, bus.branch_taken, e.taken);
    check({tag, ".busy_first"}, busy1, e.busy);
    check({tag, ".busy_at_done"}, bus.busy, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   dones;

    rst = 1'b1;
    bus.start = 1'b0;
    drive(2'b00, 3'b000, 7'b0, '0, '0);
    repeat (2) @(negedge clk);
    check("reset.result", bus.result, '0);
    check("reset.taken", bus.branch_taken, 1'b0);
    check("reset.busy", bus.busy, 1'b0);
    check("reset.done", bus.done, 1'b0);
    rst = 1'b0;

    run_op("add_mem",   OP_MEM,    3'b000, 7'b0000000, 32'd5, 32'd7, 32'd12, 1'b0, 1, 1'b0);
    run_op("sub_r",     OP_RTYPE,  3'b000, FUNC7_ALT,  32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 1'b0);
    run_op("addi_alt",  OP_ITYPE,  3'b000, FUNC7_ALT,  32'd3, 32'd5, 32'd8, 1'b0, 1, 1'b0);
    run_op("srai",      OP_ITYPE,  3'b101, FUNC7_ALT,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, 1'b0);
    run_op("sltu",      OP_RTYPE,  3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1, 1'b0);
    run_op("bltu",      OP_BRANCH, 3'b110, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1, 1'b0);
    run_op("blt",       OP_BRANCH, 3'b100, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1, 1'b0);
    run_op("bne_eq",    OP_BRANCH, 3'b001, 7'b0000000, 32'd9, 32'd9, 32'd0, 1'b0, 1, 1'b0);
    run_op("mulhu",     OP_RTYPE,  3'b011, FUNC7_MEXT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34, 1'b1);
    run_op("mulh",      OP_RTYPE,  3'b001, FUNC7_MEXT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 1'b1);
    run_op("mul",       OP_RTYPE,  3'b000, FUNC7_MEXT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 34, 1'b1);
    run_op("div",       OP_RTYPE,  3'b100, FUNC7_MEXT, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
    run_op("rem",       OP_RTYPE,  3'b110, FUNC7_MEXT, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34, 1'b1);
    run_op("divu_zero", OP_RTYPE,  3'b101, FUNC7_MEXT, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
    run_op("rem_ovf",   OP_RTYPE,  3'b110, FUNC7_MEXT, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1'b0);

    // A start pulse mid-divide must be ignored: one done, DIVU 100/7 = 14.
    sb_q.push_back('{32'd14, 1'b0, 34, 1'b1});
    @(negedge clk);
    drive(OP_RTYPE, 3'b101, FUNC7_MEXT, 32'd100, 32'd7);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drive(OP_MEM, 3'b000, 7'b0000000, 32'd1, 32'd1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 5);
    end
    bus.start = 1'b0;
    e = sb_q.pop_front();
    check("divu_ign.lat", lat, e.lat);
    check("divu_ign.result", bus.result, e.result);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("divu_ign.extra_done", dones, 0);
    check("divu_ign.hold", bus.result, 32'd14);

    // Reset at iteration 10 aborts the divide: no done, outputs back to reset values.
    @(negedge clk);
    drive(OP_RTYPE, 3'b101, FUNC7_MEXT, 32'd1000, 32'd3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("abort.no_done", dones, 0);
    check("abort.result", bus.result, '0);
    check("abort.busy", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
